mul_dispatch: RTL and testbench

Issue-side controller for the multi-cycle integer multiplier functional unit. It accepts one tagged multiply at a time from the reservation stations and drives the unit's start/operand interface. It captures the 32-bit product when the unit signals completion and queues the tagged result in a 2-entry buffer. Results are presented to the common data bus (CDB) under a request/grant handshake, so the multiplier can start its next operation while earlier results wait for the bus.

---
 rtl/mul_dispatch_if.sv | 37 +++
 rtl/mul_dispatch.sv | 122 ++++++++++++
 tb/tb_mul_dispatch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_dispatch_if
// Brief    : Issue, functional-unit and CDB signals of the multiply dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_dispatch_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic              fu_en;
    logic [DATA_W-1:0] fu_a;
    logic [DATA_W-1:0] fu_b;
    logic              fu_finish;
    logic [DATA_W-1:0] fu_res;
    logic              cdb_req;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_grant;
    logic              busy;

    modport master (
        input  issue_valid, issue_tag, issue_a, issue_b, fu_finish, fu_res, cdb_grant,
        output issue_ready, fu_en, fu_a, fu_b, cdb_req, cdb_tag, cdb_data, busy
    );

    modport slave (
        output issue_valid, issue_tag, issue_a, issue_b, fu_finish, fu_res, cdb_grant,
        input  issue_ready, fu_en, fu_a, fu_b, cdb_req, cdb_tag, cdb_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/mul_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : mul_dispatch
// Brief    : Issue-side controller for the multi-cycle multiplier with a
//            2-entry tagged result buffer drained over the CDB.
//            Optional macro MUL_DISPATCH_CDB_BYPASS_EN forwards a finishing
//            result straight to the CDB when the buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
module mul_dispatch #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    mul_dispatch_if.master  bus
);

    localparam logic [1:0] c_DRAIN = 2'd0;
    localparam logic [1:0] c_IDLE  = 2'd1;
    localparam logic [1:0] c_START = 2'd2;
    localparam logic [1:0] c_RUN   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_drain_cnt;
    logic [TAG_W-1:0]  r_inflight_tag;
    logic [DATA_W-1:0] r_fu_a;
    logic [DATA_W-1:0] r_fu_b;
    logic [TAG_W-1:0]  r_buf_tag  [2];
    logic [DATA_W-1:0] r_buf_data [2];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_count;

    logic w_accept;
    logic w_finish;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_accept = (r_state == c_IDLE) && (r_count != 2'd2) && bus.issue_valid;
    assign w_finish = (r_state == c_RUN) && bus.fu_finish;
    assign w_pop    = (r_count != 2'd0) && bus.cdb_grant;

`ifdef MUL_DISPATCH_CDB_BYPASS_EN
    // An empty buffer lets the finishing product go to the CDB this cycle.
    assign w_bypass     = w_finish && (r_count == 2'd0);
    assign w_push       = w_finish && !(w_bypass && bus.cdb_grant);
    assign bus.cdb_req  = (r_count != 2'd0) || w_bypass;
    assign bus.cdb_tag  = w_bypass ? r_inflight_tag : r_buf_tag[r_head];
    assign bus.cdb_data = w_bypass ? bus.fu_res     : r_buf_data[r_head];
`else
    assign w_bypass     = 1'b0;
    assign w_push       = w_finish && !w_bypass;
    assign bus.cdb_req  = (r_count != 2'd0);
    assign bus.cdb_tag  = r_buf_tag[r_head];
    assign bus.cdb_data = r_buf_data[r_head];
`endif

    assign bus.issue_ready = (r_state == c_IDLE) && (r_count != 2'd2);
    assign bus.fu_en       = (r_state == c_START);
    assign bus.fu_a        = r_fu_a;
    assign bus.fu_b        = r_fu_b;
    assign bus.busy        = (r_state != c_IDLE) || (r_count != 2'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_DRAIN: if (r_drain_cnt == 3'd7) w_state_nxt = c_IDLE;
            c_IDLE:  if (w_accept)            w_state_nxt = c_START;
            c_START:                          w_state_nxt = c_RUN;
            c_RUN:   if (bus.fu_finish)       w_state_nxt = c_IDLE;
            default:                          w_state_nxt = c_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_DRAIN;
            r_drain_cnt    <= 3'd0;
            r_inflight_tag <= '0;
            r_fu_a         <= '0;
            r_fu_b         <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Waits out a unit that may still be running from before reset.
            if (r_state == c_DRAIN) r_drain_cnt <= r_drain_cnt + 3'd1;
            if (w_accept) begin
                r_inflight_tag <= bus.issue_tag;
                r_fu_a         <= bus.issue_a;
                r_fu_b         <= bus.issue_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf_tag[i]  <= '0;
                r_buf_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_buf_tag[r_tail]  <= r_inflight_tag;
                r_buf_data[r_tail] <= bus.fu_res;
                r_tail             <= ~r_tail;
            end
            if (w_pop) r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_dispatch
// Brief    : Directed self-checking bench for mul_dispatch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_dispatch;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mul_dispatch_if #(.TAG_W(4), .DATA_W(32)) bus ();

    mul_dispatch #(.TAG_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the dispatcher to take the op, leaving the bench in the fu_en cycle.
    task automatic accept(input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        bus.issue_valid = 1'b1;
        bus.issue_tag   = tag;
        bus.issue_a     = a;
        bus.issue_b     = b;
        while (!bus.issue_ready && n < 40) begin
            tick();
            n++;
        end
        if (!bus.issue_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            bus.issue_valid = 1'b0;
            return;
        end
        tick();
        bus.issue_valid = 1'b0;
        check("fu_en_c1", bus.fu_en, 1);
        check("fu_a_c1", bus.fu_a, a);
        check("fu_b_c1", bus.fu_b, b);
    endtask

    task automatic ticks_fu_low(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("fu_en_low", bus.fu_en, 0);
        end
    endtask

    // Finishes in c7 with grant held high, leaves the bench in c8.
    task automatic finish_and_check(input logic [3:0] tag, input logic [31:0] res);
        bus.fu_finish = 1'b1;
        bus.fu_res    = res;
        #1;
`ifdef MUL_DISPATCH_CDB_BYPASS_EN
        check("byp_req_c7", bus.cdb_req, 1);
        check("byp_tag_c7", bus.cdb_tag, tag);
        check("byp_data_c7", bus.cdb_data, res);
        tick();
        bus.fu_finish = 1'b0;
        check("byp_req_c8", bus.cdb_req, 0);
`else
        check("req_c7", bus.cdb_req, 0);
        tick();
        bus.fu_finish = 1'b0;
        check("req_c8", bus.cdb_req, 1);
        check("tag_c8", bus.cdb_tag, tag);
        check("data_c8", bus.cdb_data, res);
`endif
        check("ready_c8", bus.issue_ready, 1);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_tag   = 4'd5;
        bus.issue_a     = 32'd7;
        bus.issue_b     = 32'd6;
        bus.fu_finish   = 1'b0;
        bus.fu_res      = 32'd0;
        bus.cdb_grant   = 1'b1;

        // Reset values and drain window
        tick();
        check("rst_ready", bus.issue_ready, 0);
        check("rst_fu_en", bus.fu_en, 0);
        check("rst_fu_ab", {bus.fu_a, bus.fu_b}, 0);
        check("rst_req", bus.cdb_req, 0);
        check("rst_cdb", {bus.cdb_tag, bus.cdb_data}, 0);
        check("rst_busy", bus.busy, 1);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("drain_ready_en_busy", {bus.issue_ready, bus.fu_en, bus.busy}, 3'b001);
            tick();
        end
        check("ready_cycle9", bus.issue_ready, 1);

        // Single op: 7*6 = 42 under tag 5
        accept(4'd5, 32'd7, 32'd6);
        ticks_fu_low(6);
        finish_and_check(4'd5, 32'd42);
        tick();
        check("single_req_done", bus.cdb_req, 0);
        check("single_busy_done", bus.busy, 0);

        // Backpressure: two results held with grant low
        bus.cdb_grant = 1'b0;
        accept(4'd1, 32'd3, 32'd4);
        ticks_fu_low(6);
        bus.fu_finish = 1'b1;
        bus.fu_res    = 32'd12;
        tick();
        bus.fu_finish = 1'b0;
        check("bp_req1", bus.cdb_req, 1);
        check("bp_head1", {bus.cdb_tag, bus.cdb_data}, {4'd1, 32'd12});
        check("bp_ready_cnt1", bus.issue_ready, 1);
        accept(4'd2, 32'hFFFF_FFFF, 32'd2);
        ticks_fu_low(6);
        check("bp_hold", {bus.cdb_tag, bus.cdb_data}, {4'd1, 32'd12});
        bus.fu_finish = 1'b1;
        bus.fu_res    = 32'hFFFF_FFFE;
        tick();
        bus.fu_finish = 1'b0;
        check("bp_full_ready", bus.issue_ready, 0);
        check("bp_full_head", {bus.cdb_req, bus.cdb_tag}, {1'b1, 4'd1});
        tick();
        check("bp_full_ready2", {bus.issue_ready, bus.busy}, 2'b01);
        bus.cdb_grant = 1'b1;
        #1;
        check("bp_pop1", {bus.cdb_tag, bus.cdb_data}, {4'd1, 32'd12});
        tick();
        check("bp_pop2", {bus.cdb_req, bus.cdb_tag, bus.cdb_data}, {1'b1, 4'd2, 32'hFFFF_FFFE});
        tick();
        check("bp_empty", bus.cdb_req, 0);

        // Push and pop in the same cycle
        bus.cdb_grant = 1'b0;
        accept(4'd3, 32'd5, 32'd5);
        ticks_fu_low(6);
        bus.fu_finish = 1'b1;
        bus.fu_res    = 32'd25;
        tick();
        bus.fu_finish = 1'b0;
        accept(4'd4, 32'd10, 32'd3);
        ticks_fu_low(6);
        bus.fu_finish = 1'b1;
        bus.fu_res    = 32'd30;
        bus.cdb_grant = 1'b1;
        #1;
        check("col_old_head", {bus.cdb_tag, bus.cdb_data}, {4'd3, 32'd25});
        tick();
        bus.fu_finish = 1'b0;
        bus.cdb_grant = 1'b0;
        check("col_new_head", {bus.cdb_req, bus.cdb_tag, bus.cdb_data}, {1'b1, 4'd4, 32'd30});
        check("col_ready", bus.issue_ready, 1);
        bus.cdb_grant = 1'b1;
        tick();
        check("col_drained", {bus.cdb_req, bus.busy}, 2'b00);

        // Stray finish in IDLE and in START
        bus.fu_finish = 1'b1;
        bus.fu_res    = 32'hDEAD;
        tick();
        bus.fu_finish = 1'b0;
        check("stray_idle", {bus.cdb_req, bus.busy, bus.issue_ready}, 3'b001);
        accept(4'd6, 32'd2, 32'd9);
        bus.fu_finish = 1'b1;
        bus.fu_res    = 32'hBAD;
        #1;
        check("stray_start_req", bus.cdb_req, 0);
        tick();
        bus.fu_finish = 1'b0;
        check("stray_start_run", {bus.cdb_req, bus.fu_en, bus.busy}, 3'b001);
        ticks_fu_low(5);
        finish_and_check(4'd6, 32'd18);
        tick();
        check("stray_done_busy", bus.busy, 0);

        // Reset during RUN; the unit still finishes inside the drain window
        accept(4'd7, 32'd4, 32'd4);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", {bus.cdb_req, bus.busy, bus.issue_ready}, 3'b010);
        tick();
        tick();
        bus.fu_finish = 1'b1;
        bus.fu_res    = 32'd16;
        #1;
        check("mid_rst_fin_req", bus.cdb_req, 0);
        tick();
        bus.fu_finish = 1'b0;
        check("mid_rst_after_fin", bus.cdb_req, 0);
        n = 0;
        while (!bus.issue_ready && n < 20) begin
            tick();
            n++;
        end
        check("mid_rst_drain_len", n, 5);
        check("mid_rst_empty", {bus.cdb_req, bus.busy}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
